// File: rtl/i281_loader.sv
// i281_loader
// Program/data loader for the i281 multicycle CPU. A host streams bytes in
// over a valid/ready handshake. Each frame is a command byte, a count byte,
// the payload and a checksum byte. The block writes code words into a
// 64 x 16 code memory and data bytes into a 16 x 8 data memory. The CPU's
// run request is held off until a frame has loaded with a correct checksum.
//
// Ports:
//   clock, reset      single clock; synchronous active-high reset
//   run               run request from the board switch
//   in_valid, in_data host byte stream
//   in_ready          loader can take a byte this cycle
//   cmem_we/addr/wdata  code memory write port (one strobe per word)
//   dmem_we/addr/wdata  data memory write port (one strobe per byte)
//   cpu_run           gated run sent to the CPU
//   busy              a frame is in progress
//   load_ok, load_err sticky status of the last frame
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high. The host may hold in_valid low for any number of cycles;
// the loader then simply waits. in_ready never depends on in_valid.
module i281_loader #(
   parameter int CADDR_W = 6,
   parameter int DADDR_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               cmem_we,
   output logic [CADDR_W-1:0] cmem_addr,
   output logic [15:0]        cmem_wdata,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [7:0]         dmem_wdata,
   output logic               cpu_run,
   output logic               busy,
   output logic               load_ok,
   output logic               load_err
);

   // One extra bit so that a full-depth count (64) fits.
   localparam int NW = CADDR_W + 1;

   localparam logic [7:0] CMD_CODE = 8'hA5;
   localparam logic [7:0] CMD_DATA = 8'h5A;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_CHI   = 3'd2,
      S_CLO   = 3'd3,
      S_DBYTE = 3'd4,
      S_CSUM  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t               state_q, state_d;
   logic                 code_mode_q, code_mode_d;
   logic [NW-1:0]        n_q, n_d;
   logic [NW-1:0]        widx_q, widx_d;
   logic [7:0]           hi_q, hi_d;
   logic [7:0]           sum_q, sum_d;
   logic                 cmem_we_q, cmem_we_d;
   logic [CADDR_W-1:0]   cmem_addr_q, cmem_addr_d;
   logic [15:0]          cmem_wdata_q, cmem_wdata_d;
   logic                 dmem_we_q, dmem_we_d;
   logic [DADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [7:0]           dmem_wdata_q, dmem_wdata_d;
   logic                 cpu_run_q, cpu_run_d;
   logic                 load_ok_q, load_ok_d;
   logic                 load_err_q, load_err_d;

   logic                 accept;
   logic                 last_item;
   logic [CADDR_W-1:0]   code_cnt;
   logic [DADDR_W-1:0]   data_cnt;

   // in_ready is forced low while reset is asserted so no byte can be
   // consumed by a frame that is about to be discarded.
   assign in_ready  = !reset && (state_q != S_DONE);
   assign accept    = in_valid && in_ready;
   assign last_item = ((widx_q + NW'(1)) == n_q);
   assign code_cnt  = in_data[CADDR_W-1:0];
   assign data_cnt  = in_data[DADDR_W-1:0];

   // ---------------- state register ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && (in_data == CMD_CODE || in_data == CMD_DATA)) begin
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (accept) state_d = code_mode_q ? S_CHI : S_DBYTE;
         end
         S_CHI: begin
            if (accept) state_d = S_CLO;
         end
         S_CLO: begin
            if (accept) state_d = last_item ? S_CSUM : S_CHI;
         end
         S_DBYTE: begin
            if (accept && last_item) state_d = S_CSUM;
         end
         S_CSUM: begin
            if (accept) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------- output / datapath logic ----------------
   always_comb begin
      code_mode_d  = code_mode_q;
      n_d          = n_q;
      widx_d       = widx_q;
      hi_d         = hi_q;
      sum_d        = sum_q;
      cmem_we_d    = 1'b0;
      cmem_addr_d  = cmem_addr_q;
      cmem_wdata_d = cmem_wdata_q;
      dmem_we_d    = 1'b0;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      load_ok_d    = load_ok_q;
      load_err_d   = load_err_q;
      // Uses the current state, so cpu_run can only rise once the FSM has
      // actually returned to IDLE after DONE.
      cpu_run_d    = run && load_ok_q && (state_q == S_IDLE);

      if (accept) begin
         case (state_q)
            S_IDLE: begin
               if (in_data == CMD_CODE || in_data == CMD_DATA) begin
                  code_mode_d = (in_data == CMD_CODE);
                  load_ok_d   = 1'b0;
                  load_err_d  = 1'b0;
                  widx_d      = '0;
                  sum_d       = '0;
               end else begin
                  load_err_d  = 1'b1;
               end
            end
            S_COUNT: begin
               // A zero count means a full memory.
               if (code_mode_q) begin
                  n_d = (code_cnt == '0) ? (NW'(1) << CADDR_W) : NW'(code_cnt);
               end else begin
                  n_d = (data_cnt == '0) ? (NW'(1) << DADDR_W) : NW'(data_cnt);
               end
            end
            S_CHI: begin
               hi_d  = in_data;
               sum_d = sum_q + in_data;
            end
            S_CLO: begin
               cmem_we_d    = 1'b1;
               cmem_addr_d  = widx_q[CADDR_W-1:0];
               cmem_wdata_d = {hi_q, in_data};
               widx_d       = widx_q + NW'(1);
               sum_d        = sum_q + in_data;
            end
            S_DBYTE: begin
               dmem_we_d    = 1'b1;
               dmem_addr_d  = widx_q[DADDR_W-1:0];
               dmem_wdata_d = in_data;
               widx_d       = widx_q + NW'(1);
               sum_d        = sum_q + in_data;
            end
            S_CSUM: begin
               if (in_data == sum_q) begin
                  load_ok_d  = 1'b1;
               end else begin
                  load_err_d = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------- datapath / output registers ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         code_mode_q  <= 1'b0;
         n_q          <= '0;
         widx_q       <= '0;
         hi_q         <= '0;
         sum_q        <= '0;
         cmem_we_q    <= 1'b0;
         cmem_addr_q  <= '0;
         cmem_wdata_q <= '0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         cpu_run_q    <= 1'b0;
         load_ok_q    <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         code_mode_q  <= code_mode_d;
         n_q          <= n_d;
         widx_q       <= widx_d;
         hi_q         <= hi_d;
         sum_q        <= sum_d;
         cmem_we_q    <= cmem_we_d;
         cmem_addr_q  <= cmem_addr_d;
         cmem_wdata_q <= cmem_wdata_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         cpu_run_q    <= cpu_run_d;
         load_ok_q    <= load_ok_d;
         load_err_q   <= load_err_d;
      end
   end

   assign cmem_we    = cmem_we_q;
   assign cmem_addr  = cmem_addr_q;
   assign cmem_wdata = cmem_wdata_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign cpu_run    = cpu_run_q;
   assign busy       = (state_q != S_IDLE);
   assign load_ok    = load_ok_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_i281_loader.sv
// Testbench for i281_loader: a cycle table for code/data frames with gaps,
// a DONE-cycle byte and a bad command, plus hand-written sequences for a
// bad checksum, a full 64-word code frame and a mid-frame reset. Memory
// writes are checked by a monitor against expected queues.
module tb_i281_loader;

   logic        clock;
   logic        reset;
   logic        run;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        cmem_we;
   logic [5:0]  cmem_addr;
   logic [15:0] cmem_wdata;
   logic        dmem_we;
   logic [3:0]  dmem_addr;
   logic [7:0]  dmem_wdata;
   logic        cpu_run;
   logic        busy;
   logic        load_ok;
   logic        load_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [21:0] cexp_q[$];   // {addr, data}
   logic [11:0] dexp_q[$];   // {addr, data}

   i281_loader dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .cmem_we    (cmem_we),
      .cmem_addr  (cmem_addr),
      .cmem_wdata (cmem_wdata),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .cpu_run    (cpu_run),
      .busy       (busy),
      .load_ok    (load_ok),
      .load_err   (load_err)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Write monitor, sampled mid-cycle on the falling edge.
   always @(negedge clock) begin
      if (cmem_we === 1'b1) begin
         n_cmp++;
         if (cexp_q.size() == 0) begin
            n_bad++;
            $display("FAIL cmem_write: unexpected write addr %h data %h", cmem_addr, cmem_wdata);
         end else begin
            logic [21:0] e;
            e = cexp_q.pop_front();
            if ({cmem_addr, cmem_wdata} !== e) begin
               n_bad++;
               $display("FAIL cmem_write: got %h/%h expected %h/%h", cmem_addr, cmem_wdata, e[21:16], e[15:0]);
            end
         end
      end
      if (dmem_we === 1'b1) begin
         n_cmp++;
         if (dexp_q.size() == 0) begin
            n_bad++;
            $display("FAIL dmem_write: unexpected write addr %h data %h", dmem_addr, dmem_wdata);
         end else begin
            logic [11:0] e;
            e = dexp_q.pop_front();
            if ({dmem_addr, dmem_wdata} !== e) begin
               n_bad++;
               $display("FAIL dmem_write: got %h/%h expected %h/%h", dmem_addr, dmem_wdata, e[11:8], e[7:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Offer one byte and wait (bounded) until it is accepted.
   task automatic send_byte(input logic [7:0] b);
      logic got;
      got = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 20 && !got; i++) begin
         got = in_ready;
         tick();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL accept_timeout: byte %h got no in_ready", b);
      end
   endtask

   // ---------------- table ----------------
   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       run;
      logic       exp_ready;
      logic       exp_busy;
      logic       exp_ok;
      logic       exp_err;
      logic       exp_cpu;
   } vec_t;

   vec_t vecs[23];

   initial begin
      // valid, data, run | ready, busy, ok, err, cpu_run (after the edge)
      vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 8'h90, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // csum -> DONE
      vecs[7]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // byte ignored in DONE
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // cpu_run 2 cycles after csum
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // run low
      vecs[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}; // bad command
      vecs[11] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // clears status
      vecs[12] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // cpu_run drops
      vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] sum;
      logic [7:0] hi;
      logic [7:0] lo;

      reset    = 1'b1;
      run      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1;
      check("ready_in_reset", in_ready, 1'b0);
      tick();
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_ok", load_ok, 1'b0);
      check("rst_err", load_err, 1'b0);
      check("rst_cpu_run", cpu_run, 1'b0);
      check("rst_cmem_we", cmem_we, 1'b0);
      check("rst_dmem_we", dmem_we, 1'b0);
      reset = 1'b0;
      #1;
      check("ready_after_reset", in_ready, 1'b1);
      tick();

      // Table: code frame, DONE bubble, bad command, data frame with gaps.
      cexp_q.push_back({6'd0, 16'h8105});
      cexp_q.push_back({6'd1, 16'h900A});
      dexp_q.push_back({4'd0, 8'h11});
      dexp_q.push_back({4'd1, 8'h22});
      dexp_q.push_back({4'd2, 8'h33});
      for (int i = 0; i < 23; i++) begin
         in_valid = vecs[i].valid;
         in_data  = vecs[i].data;
         run      = vecs[i].run;
         tick();
         check($sformatf("vec%0d_ready", i), in_ready, vecs[i].exp_ready);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
         check($sformatf("vec%0d_ok", i), load_ok, vecs[i].exp_ok);
         check($sformatf("vec%0d_err", i), load_err, vecs[i].exp_err);
         check($sformatf("vec%0d_cpu_run", i), cpu_run, vecs[i].exp_cpu);
      end
      in_valid = 1'b0;
      check("table_cmem_drained", cexp_q.size(), 0);
      check("table_dmem_drained", dexp_q.size(), 0);

      // Bad checksum: writes still happen, cpu_run stays low.
      run = 1'b1;
      cexp_q.push_back({6'd0, 16'h8105});
      cexp_q.push_back({6'd1, 16'h900A});
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h81);
      send_byte(8'h05);
      send_byte(8'h90);
      send_byte(8'h0A);
      send_byte(8'h21);
      check("badsum_ok", load_ok, 1'b0);
      check("badsum_err", load_err, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("badsum_cpu_run", cpu_run, 1'b0);
      end
      check("badsum_writes", cexp_q.size(), 0);

      // Count 0 in code mode: 64 words at addresses 0..63.
      sum = 8'h00;
      send_byte(8'hA5);
      send_byte(8'hC0); // upper bits ignored, count 0 -> 64
      for (int i = 0; i < 64; i++) begin
         hi = 8'(i);
         lo = 8'(i * 3 + 7);
         sum = sum + hi + lo;
         cexp_q.push_back({6'(i), hi, lo});
         send_byte(hi);
         send_byte(lo);
      end
      send_byte(sum);
      check("full_ok", load_ok, 1'b1);
      check("full_err", load_err, 1'b0);
      tick();
      check("full_idle_busy", busy, 1'b0);
      check("full_idle_ready", in_ready, 1'b1);
      check("full_writes", cexp_q.size(), 0);
      tick();
      check("full_cpu_run", cpu_run, 1'b1);

      // Reset after the CHI byte, then a clean data frame.
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'hEE);
      reset = 1'b1;
      #1;
      check("midrst_ready_low", in_ready, 1'b0);
      tick();
      check("midrst_busy", busy, 1'b0);
      check("midrst_ok", load_ok, 1'b0);
      check("midrst_err", load_err, 1'b0);
      check("midrst_cpu_run", cpu_run, 1'b0);
      check("midrst_cmem_we", cmem_we, 1'b0);
      check("midrst_cmem_addr", cmem_addr, 6'd0);
      check("midrst_cmem_wdata", cmem_wdata, 16'h0000);
      check("midrst_dmem_we", dmem_we, 1'b0);
      check("midrst_dmem_addr", dmem_addr, 4'd0);
      check("midrst_dmem_wdata", dmem_wdata, 8'h00);
      reset = 1'b0;
      #1;
      check("midrst_ready_back", in_ready, 1'b1);
      dexp_q.push_back({4'd0, 8'h7E});
      send_byte(8'h5A);
      send_byte(8'h01);
      send_byte(8'h7E);
      send_byte(8'h7E);
      check("post_rst_ok", load_ok, 1'b1);
      check("post_rst_err", load_err, 1'b0);
      tick();
      tick();
      check("post_rst_cpu_run", cpu_run, 1'b1);
      check("final_cmem_drained", cexp_q.size(), 0);
      check("final_dmem_drained", dexp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
